// File: rtl/grid_defs.sv
// Shared definitions for the level grid and the VGA plot interface.
// Used by grid_renderer and level_loader.
//   - grid geometry (GRID_W x GRID_H cells, CELL_PX x CELL_PX pixels per cell)
//   - address and VGA field widths
//   - cell value codes and the renderer state encoding
//   - LINE_COLOUR, only referenced when GRID_RENDERER_GRIDLINES_EN is defined
package grid_defs;

    localparam int GRID_W    = 40;
    localparam int GRID_H    = 30;
    localparam int CELL_PX   = 4;
    localparam int CELL_BITS = $clog2(CELL_PX);
    localparam int SUB_W     = 2 * CELL_BITS;

    localparam int GX_W      = 6;
    localparam int GY_W      = 5;
    localparam int VGA_X_W   = 8;
    localparam int VGA_Y_W   = 7;
    localparam int COLOUR_W  = 3;

    localparam logic [COLOUR_W-1:0] LINE_COLOUR = 3'b111;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        WALL   = 3'd1,
        FLOOR  = 3'd2,
        PLAYER = 3'd3,
        GOAL   = 3'd4
    } cell_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        FETCH = 3'd2,
        LATCH = 3'd3,
        DRAW  = 3'd4,
        NEXT  = 3'd5,
        DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/grid_renderer_datapath.sv
// Datapath for grid_renderer: cell address counters, sub-pixel counter,
// latched cell value, pixel address and colour.
// Ports:
//   clock, reset             system clock, async active-low reset
//   clr/latch/draw/advance   control strobes from the FSM
//   grid_out                 grid memory read data
//   grid_x, grid_y           grid read address
//   sub_last, last_cell      status back to the FSM
//   vga_x, vga_y, vga_colour pixel address and colour
// Macro GRID_RENDERER_GRIDLINES_EN: draw the right and bottom pixel edge of
// every cell in LINE_COLOUR.
module grid_renderer_datapath
    import grid_defs::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                clr,
    input  logic                latch,
    input  logic                draw,
    input  logic                advance,
    input  logic [COLOUR_W-1:0] grid_out,
    output logic [GX_W-1:0]     grid_x,
    output logic [GY_W-1:0]     grid_y,
    output logic                sub_last,
    output logic                last_cell,
    output logic [VGA_X_W-1:0]  vga_x,
    output logic [VGA_Y_W-1:0]  vga_y,
    output logic [COLOUR_W-1:0] vga_colour
);

    logic [SUB_W-1:0]     sub;
    logic [COLOUR_W-1:0]  cell_reg;
    logic [CELL_BITS-1:0] sub_x;
    logic [CELL_BITS-1:0] sub_y;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grid_x   <= '0;
            grid_y   <= '0;
            sub      <= '0;
            cell_reg <= '0;
        end else begin
            if (clr) begin
                grid_x <= '0;
                grid_y <= '0;
                sub    <= '0;
            end
            if (latch) cell_reg <= grid_out;
            // sub wraps to 0 after the last pixel, ready for the next cell
            if (draw) sub <= sub + SUB_W'(1);
            if (advance) begin
                if (grid_x == GX_W'(GRID_W - 1)) begin
                    grid_x <= '0;
                    grid_y <= grid_y + GY_W'(1);
                end else begin
                    grid_x <= grid_x + GX_W'(1);
                end
            end
        end
    end

    assign sub_x     = sub[CELL_BITS-1:0];
    assign sub_y     = sub[SUB_W-1:CELL_BITS];
    assign sub_last  = (sub == {SUB_W{1'b1}});
    assign last_cell = (grid_x == GX_W'(GRID_W - 1)) && (grid_y == GY_W'(GRID_H - 1));

    // CELL_PX is a power of two, so grid*CELL_PX + sub is a concatenation.
    assign vga_x = {grid_x, sub_x};
    assign vga_y = {grid_y, sub_y};

`ifdef GRID_RENDERER_GRIDLINES_EN
    assign vga_colour = ((sub_x == CELL_BITS'(CELL_PX - 1)) || (sub_y == CELL_BITS'(CELL_PX - 1)))
                        ? LINE_COLOUR : cell_reg;
`else
    assign vga_colour = cell_reg;
`endif

endmodule

// File: rtl/grid_renderer_fsm.sv
// Sequencing FSM for grid_renderer.
// Ports:
//   clock, reset     system clock, async active-low reset
//   start            render request, only honoured in IDLE
//   sub_last         datapath sub counter is at its final pixel
//   last_cell        datapath address is the bottom-right cell
//   clr/latch/draw/advance  datapath control strobes
//   done, busy       handshake outputs
//
//   state | meaning
//   IDLE  | waiting for start, counters hold
//   INIT  | clear cell address and sub counter
//   FETCH | address presented to grid memory
//   LATCH | capture grid_out into cell_reg
//   DRAW  | plot CELL_PX*CELL_PX pixels of the current cell
//   NEXT  | step to the next cell (row-major)
//   DONE  | one-cycle completion pulse
module grid_renderer_fsm
    import grid_defs::*;
(
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic sub_last,
    input  logic last_cell,
    output logic clr,
    output logic latch,
    output logic draw,
    output logic advance,
    output logic done,
    output logic busy
);

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // All outputs decode the state register directly, so reset clears them
    // asynchronously along with the state.
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        latch     = 1'b0;
        draw      = 1'b0;
        advance   = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = INIT;
            end
            INIT: begin
                clr       = 1'b1;
                state_nxt = FETCH;
            end
            FETCH: state_nxt = LATCH;
            LATCH: begin
                latch     = 1'b1;
                state_nxt = DRAW;
            end
            DRAW: begin
                draw = 1'b1;
                if (sub_last) state_nxt = last_cell ? DONE : NEXT;
            end
            NEXT: begin
                advance   = 1'b1;
                state_nxt = FETCH;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/grid_renderer.sv
// grid_renderer: reads the 40x30 level grid and plots each cell as a
// CELL_PX x CELL_PX block on the 160x120 VGA plot interface.
// Ports:
//   clock, reset   system clock, async active-low reset
//   start          begin a full render (ignored while busy)
//   done           one-cycle completion pulse
//   busy           high outside IDLE
//   grid_x, grid_y grid read address; grid_out valid one cycle later
//   vga_x, vga_y, vga_colour, vga_plot  VGA adapter plot interface
// Optional macro GRID_RENDERER_GRIDLINES_EN overlays grid lines in
// LINE_COLOUR; timing is identical either way.
module grid_renderer
    import grid_defs::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                done,
    output logic                busy,
    output logic [GX_W-1:0]     grid_x,
    output logic [GY_W-1:0]     grid_y,
    input  logic [COLOUR_W-1:0] grid_out,
    output logic [VGA_X_W-1:0]  vga_x,
    output logic [VGA_Y_W-1:0]  vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    logic clr;
    logic latch;
    logic draw;
    logic advance;
    logic sub_last;
    logic last_cell;

    grid_renderer_fsm u_fsm (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .sub_last  (sub_last),
        .last_cell (last_cell),
        .clr       (clr),
        .latch     (latch),
        .draw      (draw),
        .advance   (advance),
        .done      (done),
        .busy      (busy)
    );

    grid_renderer_datapath u_datapath (
        .clock      (clock),
        .reset      (reset),
        .clr        (clr),
        .latch      (latch),
        .draw       (draw),
        .advance    (advance),
        .grid_out   (grid_out),
        .grid_x     (grid_x),
        .grid_y     (grid_y),
        .sub_last   (sub_last),
        .last_cell  (last_cell),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour)
    );

    assign vga_plot = draw;

endmodule
